// File: rtl/clct_subkey_decoder.sv
// Unpacks sorted CLCT subkeys into CFEB / half-strip / quarter- and eighth-strip fields
// and buffers the decoded words in a first-word-fall-through FIFO toward readout.
module clct_subkey_decoder #(
    parameter int MXPATB     = 4,
    parameter int MXKEYBX    = 8,
    parameter int MXXKYB     = 10,
    parameter int MXBNDB     = 5,
    parameter int MXPATC     = 12,
    parameter int MXKEYMAX   = 223,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clct_vld,
    input  logic               clct_bsy,
    input  logic [MXPATB-1:0]  clct_pat,
    input  logic [MXXKYB-1:0]  clct_subkey,
    input  logic [MXBNDB-1:0]  clct_bend,
    input  logic [MXPATC-1:0]  clct_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         out_cfeb,
    output logic [4:0]         out_hs,
    output logic [MXKEYBX-1:0] out_key,
    output logic               out_qs,
    output logic               out_es,
    output logic [MXPATB-1:0]  out_pat,
    output logic [MXBNDB-1:0]  out_bend,
    output logic [MXPATC-1:0]  out_carry,
    output logic               out_rng_err,
    output logic               fifo_full,
    output logic [15:0]        ovf_cnt
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = 1 + MXKEYBX + 2 + MXPATB + MXBNDB + MXPATC;
    localparam logic [AW:0]        FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [MXKEYBX-1:0] KEY_MAX  = MXKEYBX'(MXKEYMAX);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 1: register accepted sorter output
    logic               vld_p1;
    logic [MXPATB-1:0]  pat_p1;
    logic [MXXKYB-1:0]  subkey_p1;
    logic [MXBNDB-1:0]  bend_p1;
    logic [MXPATC-1:0]  carry_p1;

    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= clct_vld & ~clct_bsy;
    end

    always_ff @(posedge clock) begin
        pat_p1    <= clct_pat;
        subkey_p1 <= clct_subkey;
        bend_p1   <= clct_bend;
        carry_p1  <= clct_carry;
    end

    // Stage 2: decode; low subkey bits carry the offset code biased by +1
    logic [MXKEYBX-1:0] key_p1;
    logic [1:0]         es_code_p1;
    logic               vld_p2;
    logic [WORD_W-1:0]  word_p2;

    assign key_p1     = subkey_p1[MXXKYB-1:2];
    assign es_code_p1 = subkey_p1[1:0] - 2'd1;

    always_ff @(posedge clock) begin
        if (reset) vld_p2 <= 1'b0;
        else       vld_p2 <= vld_p1;
    end

    always_ff @(posedge clock) begin
        word_p2 <= {key_p1 > KEY_MAX, key_p1, es_code_p1[1], es_code_p1[0],
                    pat_p1, bend_p1, carry_p1};
    end

    // Stage 3: FIFO write; a pop frees the slot being written when full
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              pop, wr_en;
    logic [WORD_W-1:0] head;

    assign out_valid = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = out_valid & out_ready;
    assign wr_en     = vld_p2 & (~fifo_full | pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (vld_p2 && !wr_en) ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= word_p2;
    end

    // Head word is forced to zero while empty so stale entries never appear
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_rng_err, out_key, out_qs, out_es, out_pat, out_bend, out_carry} = head;
    assign out_cfeb = out_key[MXKEYBX-1 -: 3];
    assign out_hs   = out_key[4:0];

endmodule

// File: tb/tb_clct_subkey_decoder.sv
// Directed and randomized bench for clct_subkey_decoder against a queue-based reference model.
module tb_clct_subkey_decoder;

    logic        clk = 1'b0;
    logic        reset, clct_vld, clct_bsy, out_ready;
    logic [3:0]  clct_pat;
    logic [9:0]  clct_subkey;
    logic [4:0]  clct_bend;
    logic [11:0] clct_carry;
    logic        out_valid, out_qs, out_es, out_rng_err, fifo_full;
    logic [2:0]  out_cfeb;
    logic [4:0]  out_hs, out_bend;
    logic [7:0]  out_key;
    logic [3:0]  out_pat;
    logic [11:0] out_carry;
    logic [15:0] ovf_cnt;

    always #5 clk = ~clk;

    clct_subkey_decoder dut (
        .clock(clk), .reset(reset), .clct_vld(clct_vld), .clct_bsy(clct_bsy),
        .clct_pat(clct_pat), .clct_subkey(clct_subkey), .clct_bend(clct_bend),
        .clct_carry(clct_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_cfeb(out_cfeb), .out_hs(out_hs), .out_key(out_key), .out_qs(out_qs),
        .out_es(out_es), .out_pat(out_pat), .out_bend(out_bend), .out_carry(out_carry),
        .out_rng_err(out_rng_err), .fifo_full(fifo_full), .ovf_cnt(ovf_cnt)
    );

    typedef struct packed {
        logic [3:0]  pat;
        logic [9:0]  subkey;
        logic [4:0]  bend;
        logic [11:0] carry;
    } item_t;

    item_t q[$];
    item_t d1, d2;
    bit    d1v, d2v;
    int    ovf_m;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: two clocks of transport, then a bounded queue of 8 words
    task automatic model_edge();
        bit pop_m, full_m;
        if (reset) begin
            q.delete();
            d1v = 0; d2v = 0; ovf_m = 0;
            return;
        end
        full_m = (q.size() == 8);
        pop_m  = out_ready && (q.size() > 0);
        if (pop_m) void'(q.pop_front());
        if (d2v) begin
            if (full_m && !pop_m) ovf_m = (ovf_m >= 65535) ? 65535 : ovf_m + 1;
            else q.push_back(d2);
        end
        d2v = d1v; d2 = d1;
        d1v = clct_vld && !clct_bsy;
        d1  = '{pat: clct_pat, subkey: clct_subkey, bend: clct_bend, carry: clct_carry};
    endtask

    task automatic compare_all();
        item_t h;
        int key, lo, code;
        chk("valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            h    = q[0];
            key  = int'(h.subkey) / 4;
            lo   = int'(h.subkey) % 4;
            code = (lo + 3) % 4;
            chk("key",   32'(out_key),     32'(key));
            chk("cfeb",  32'(out_cfeb),    32'(key / 32));
            chk("hs",    32'(out_hs),      32'(key % 32));
            chk("qs",    32'(out_qs),      32'(code / 2));
            chk("es",    32'(out_es),      32'(code % 2));
            chk("rng",   32'(out_rng_err), 32'(key > 223));
            chk("pat",   32'(out_pat),     32'(h.pat));
            chk("bend",  32'(out_bend),    32'(h.bend));
            chk("carry", 32'(out_carry),   32'(h.carry));
        end else begin
            chk("idle_data", {out_rng_err, out_key, out_qs, out_es, out_pat, out_bend, out_carry[8:0]}, 32'd0);
        end
        chk("full", 32'(fifo_full), 32'(q.size() == 8));
        chk("ovf",  32'(ovf_cnt),   32'(ovf_m));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic vld, input logic [7:0] key, input logic [1:0] lo, input logic [3:0] pat);
        clct_vld    = vld;
        clct_subkey = {key, lo};
        clct_pat    = pat;
        clct_bend   = 5'($urandom);
        clct_carry  = 12'($urandom);
    endtask

    initial begin
        reset = 1; clct_vld = 0; clct_bsy = 0; out_ready = 0;
        clct_pat = 0; clct_subkey = 0; clct_bend = 0; clct_carry = 0;
        d1 = '0; d2 = '0; d1v = 0; d2v = 0; ovf_m = 0;
        #1;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        reset = 0;

        // Basic decode, 3-clock latency
        drive(1, 8'd37, 2'b01, 4'hA); step();
        clct_vld = 0; step();
        chk("lat_early", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_cfeb", 32'(out_cfeb), 32'd1);
        chk("t1_hs", 32'(out_hs), 32'd5);
        chk("t1_key", 32'(out_key), 32'd37);
        chk("t1_qses", {out_qs, out_es}, 32'd0);
        chk("t1_pat", 32'(out_pat), 32'hA);
        out_ready = 1; step(); out_ready = 0;

        // Range edge and out-of-range key
        drive(1, 8'd223, 2'b00, 4'h3); step();
        drive(1, 8'd230, 2'b10, 4'h4); step();
        clct_vld = 0; step(); step();
        chk("t2_key", 32'(out_key), 32'd223);
        chk("t2_cfebhs", {out_cfeb, out_hs}, {3'd6, 5'd31});
        chk("t2_qses", {out_qs, out_es, out_rng_err}, 32'b110);
        out_ready = 1; step(); out_ready = 0;
        chk("t2b_rng", {out_rng_err, out_qs, out_es}, 32'b101);
        out_ready = 1; step(); step();

        // Busy suppresses accepts
        out_ready = 0; clct_bsy = 1;
        for (int i = 0; i < 5; i++) begin drive(1, 8'(i), 2'b01, 4'h1); step(); end
        clct_bsy = 0; clct_vld = 0;
        for (int i = 0; i < 3; i++) step();
        chk("t3_valid", 32'(out_valid), 32'd0);
        chk("t3_ovf", 32'(ovf_cnt), 32'd0);

        // Overflow: 10 pushes into 8 slots
        for (int i = 0; i < 10; i++) begin drive(1, 8'(i), 2'b01, 4'h2); step(); end
        clct_vld = 0; step(); step();
        chk("t4_full", 32'(fifo_full), 32'd1);
        chk("t4_ovf", 32'(ovf_cnt), 32'd2);
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin chk("t4_order", 32'(out_key), 32'(i)); step(); end
        chk("t4_empty", 32'(out_valid), 32'd0);

        // Push and pop together while full
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin drive(1, 8'(20 + i), 2'b11, 4'h5); step(); end
        clct_vld = 0; step(); step();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, 8'(40 + i), 2'b10, 4'h6); else clct_vld = 0;
            out_ready = (i >= 2);
            step();
        end
        out_ready = 0;
        chk("t5_full", 32'(fifo_full), 32'd1);
        chk("t5_ovf", 32'(ovf_cnt), 32'd2);
        chk("t5_head", 32'(out_key), 32'd24);
        out_ready = 1;
        for (int i = 0; i < 9; i++) step();

        // Reset mid-stream flushes everything
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 8'(60 + i), 2'b01, 4'h7); step(); end
        reset = 1; drive(1, 8'd99, 2'b01, 4'h8); step();
        reset = 0; clct_vld = 0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_ovf", 32'(ovf_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t6_stale", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            clct_vld    = ($urandom_range(0, 3) != 0);
            clct_bsy    = ($urandom_range(0, 7) == 0);
            clct_subkey = 10'($urandom);
            clct_pat    = 4'($urandom);
            clct_bend   = 5'($urandom);
            clct_carry  = 12'($urandom);
            out_ready   = ($urandom_range(0, 2) == 0);
            step();
        end
        clct_vld = 0; out_ready = 1;
        for (int i = 0; i < 12; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
